// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin sharing of one register-bank port between port A (SPI side) and port B (I2C side).
module reg_bank_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena_i,
    input  logic              a_req_i,
    input  logic              a_wr_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    output logic              a_ack_o,
    output logic [DATA_W-1:0] a_rdata_o,
    input  logic              b_req_i,
    input  logic              b_wr_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic              b_ack_o,
    output logic [DATA_W-1:0] b_rdata_o,
    output logic [ADDR_W-1:0] bank_addr_o,
    output logic [DATA_W-1:0] bank_wdata_o,
    output logic              bank_we_o,
    output logic              bank_re_o,
    input  logic [DATA_W-1:0] bank_rdata_i,
    output logic              busy_o,
    output logic              grant_id_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t            state_q;
    logic              dir_q, grant_q, prio_b_q, we_q, re_q, a_ack_q, b_ack_q;
    logic [1:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, a_rdata_q, b_rdata_q;
    logic              win_b_d, wr_d;
    // B wins outright when alone, or on a tie when A was granted last
    assign win_b_d = b_req_i & (~a_req_i | prio_b_q);
    assign wr_d    = win_b_d ? b_wr_i : a_wr_i;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dir_q     <= 1'b0;
            grant_q   <= 1'b0;
            prio_b_q  <= 1'b0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state_q)
                IDLE: if (ena_i && (a_req_i || b_req_i)) begin
                    state_q  <= ISSUE;
                    grant_q  <= win_b_d;
                    prio_b_q <= ~win_b_d;
                    dir_q    <= wr_d;
                    we_q     <= wr_d;
                    re_q     <= ~wr_d;
                    addr_q   <= win_b_d ? b_addr_i : a_addr_i;
                    wdata_q  <= win_b_d ? b_wdata_i : a_wdata_i;
                end
                ISSUE: begin
                    state_q <= dir_q ? DONE : WAIT;
                    cnt_q   <= 2'(RD_LATENCY - 1);
                    a_ack_q <= dir_q & ~grant_q;
                    b_ack_q <= dir_q & grant_q;
                end
                WAIT: if (cnt_q == 2'd0) begin
                    state_q <= DONE;
                    a_ack_q <= ~grant_q;
                    b_ack_q <= grant_q;
                    if (grant_q) b_rdata_q <= bank_rdata_i;
                    else a_rdata_q <= bank_rdata_i;
                end else begin
                    cnt_q <= cnt_q - 2'd1;
                end
                DONE: state_q <= IDLE;
            endcase
        end
    end
    assign a_ack_o      = a_ack_q;
    assign b_ack_o      = b_ack_q;
    assign a_rdata_o    = a_rdata_q;
    assign b_rdata_o    = b_rdata_q;
    assign bank_addr_o  = addr_q;
    assign bank_wdata_o = wdata_q;
    assign bank_we_o    = we_q;
    assign bank_re_o    = re_q;
    assign busy_o       = state_q != IDLE;
    assign grant_id_o   = grant_q;
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: directed and randomized checks of reg_bank_arbiter against a transaction-level model.
module tb_reg_bank_arbiter;
    localparam int L = 1;
    logic       clk = 0, rst_n = 0, ena = 0;
    logic       a_req = 0, a_wr = 0, b_req = 0, b_wr = 0;
    logic [7:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
    logic [7:0] bank_rdata = 0;
    logic       a_ack, b_ack, bank_we, bank_re, busy, grant_id;
    logic [7:0] a_rdata, b_rdata, bank_addr, bank_wdata;
    logic [7:0] mem [256];
    logic [7:0] shadow [256];
    logic [7:0] exp_rd_a = 0, exp_rd_b = 0;
    bit         last_b = 1;
    int         vec = 0, errs = 0;
    logic       sw_req = 0;
    logic [7:0] sw_addr = 0;
    logic       sw_ack [4], sw_bk [4], sw_we [4], sw_re [4], sw_busy [4], sw_gid [4];
    logic [7:0] sw_rdata [4], sw_brd [4], sw_baddr [4], sw_bwd [4], sw_brdata [4];

    always #5 clk = ~clk;

    reg_bank_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .ena_i(ena),
        .a_req_i(a_req), .a_wr_i(a_wr), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_ack_o(a_ack), .a_rdata_o(a_rdata),
        .b_req_i(b_req), .b_wr_i(b_wr), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_ack_o(b_ack), .b_rdata_o(b_rdata),
        .bank_addr_o(bank_addr), .bank_wdata_o(bank_wdata), .bank_we_o(bank_we),
        .bank_re_o(bank_re), .bank_rdata_i(bank_rdata),
        .busy_o(busy), .grant_id_o(grant_id)
    );

    // bank returns real data only in the cycle after a read strobe, garbage otherwise
    always @(posedge clk) begin
        if (bank_we) mem[bank_addr] <= bank_wdata;
        bank_rdata <= bank_re ? mem[bank_addr] : ~mem[bank_addr];
    end

    for (genvar g = 0; g < 4; g++) begin : sw
        logic [7:0] pipe [4];
        always @(posedge clk) begin
            pipe[0] <= sw_re[g] ? (sw_baddr[g] ^ 8'h5A) : ~(sw_baddr[g] ^ 8'h5A);
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        assign sw_brdata[g] = pipe[g];
        reg_bank_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(g + 1)) u_dut (
            .clk(clk), .rst_n(rst_n), .ena_i(1'b1),
            .a_req_i(sw_req), .a_wr_i(1'b0), .a_addr_i(sw_addr), .a_wdata_i(8'h00),
            .a_ack_o(sw_ack[g]), .a_rdata_o(sw_rdata[g]),
            .b_req_i(1'b0), .b_wr_i(1'b0), .b_addr_i(8'h00), .b_wdata_i(8'h00),
            .b_ack_o(sw_bk[g]), .b_rdata_o(sw_brd[g]),
            .bank_addr_o(sw_baddr[g]), .bank_wdata_o(sw_bwd[g]), .bank_we_o(sw_we[g]),
            .bank_re_o(sw_re[g]), .bank_rdata_i(sw_brdata[g]),
            .busy_o(sw_busy[g]), .grant_id_o(sw_gid[g])
        );
    end

    task automatic test_reset();
        ena = 1; a_req = 1; b_req = 1;
        repeat (3) @(negedge clk);
        vec++; if ({a_ack, b_ack, bank_we, bank_re, busy, grant_id} !== 6'b0) begin
            errs++; $display("FAIL reset_ctrl: got %b want 000000", {a_ack, b_ack, bank_we, bank_re, busy, grant_id});
        end
        vec++; if ({a_rdata, b_rdata} !== 16'h0) begin
            errs++; $display("FAIL reset_rdata: got %h want 0000", {a_rdata, b_rdata});
        end
        vec++; if ({bank_addr, bank_wdata} !== 16'h0) begin
            errs++; $display("FAIL reset_bank: got %h want 0000", {bank_addr, bank_wdata});
        end
        a_req = 0; b_req = 0; rst_n = 1;
        @(negedge clk);
        vec++; if (busy !== 1'b0) begin
            errs++; $display("FAIL reset_idle: busy got %b want 0", busy);
        end
    endtask

    task automatic test_write_a();
        bit seen_b = 0;
        a_wr = 1; a_addr = 8'h05; a_wdata = 8'hA5; a_req = 1;
        @(negedge clk);
        seen_b |= b_ack;
        vec++; if ({bank_we, bank_re, bank_addr, bank_wdata, a_ack} !== {2'b10, 8'h05, 8'hA5, 1'b0}) begin
            errs++; $display("FAIL wr_a_strobe: got we=%b re=%b addr=%h wd=%h ack=%b want 1 0 05 a5 0",
                             bank_we, bank_re, bank_addr, bank_wdata, a_ack);
        end
        @(negedge clk);
        seen_b |= b_ack;
        vec++; if (a_ack !== 1'b1) begin
            errs++; $display("FAIL wr_a_ack: got %b want 1", a_ack);
        end
        a_req = 0;
        repeat (2) begin @(negedge clk); seen_b |= b_ack; end
        vec++; if (seen_b !== 1'b0) begin
            errs++; $display("FAIL wr_a_no_b_ack: got %b want 0", seen_b);
        end
        shadow[8'h05] = 8'hA5; last_b = 0;
    endtask

    task automatic test_read_b();
        mem[8'h03] <= 8'h3C; shadow[8'h03] = 8'h3C;
        b_wr = 0; b_addr = 8'h03; b_req = 1;
        @(negedge clk);
        vec++; if ({bank_re, bank_we, bank_addr} !== {2'b10, 8'h03}) begin
            errs++; $display("FAIL rd_b_strobe: got re=%b we=%b addr=%h want 1 0 03", bank_re, bank_we, bank_addr);
        end
        @(negedge clk);
        vec++; if (b_ack !== 1'b0) begin
            errs++; $display("FAIL rd_b_early_ack: got %b want 0", b_ack);
        end
        @(negedge clk);
        vec++; if ({b_ack, b_rdata} !== {1'b1, 8'h3C}) begin
            errs++; $display("FAIL rd_b_ack: got ack=%b rdata=%h want 1 3c", b_ack, b_rdata);
        end
        vec++; if (a_rdata !== exp_rd_a) begin
            errs++; $display("FAIL rd_b_a_hold: got %h want %h", a_rdata, exp_rd_a);
        end
        b_req = 0; exp_rd_b = 8'h3C; last_b = 1;
        @(negedge clk);
    endtask

    task automatic test_alternate();
        int n = 0, last_t = 0;
        logic [7:0] da, db;
        rst_n = 0; #1; rst_n = 1;
        exp_rd_a = 0; exp_rd_b = 0; last_b = 1;
        da = 8'($urandom); db = 8'($urandom);
        a_wr = 1; a_addr = 8'h10; a_wdata = da; b_wr = 1; b_addr = 8'h20; b_wdata = db;
        a_req = 1; b_req = 1;
        for (int t = 1; t <= 40 && n < 6; t++) begin
            @(negedge clk);
            vec++; if (a_ack && b_ack) begin
                errs++; $display("FAIL alt_both_ack: got 11 want one-hot at t=%0d", t);
            end
            if (a_ack || b_ack) begin
                vec++; if ({b_ack, grant_id} !== {2{1'(n % 2)}}) begin
                    errs++; $display("FAIL alt_order: txn %0d got b_ack=%b grant=%b want %0d", n, b_ack, grant_id, n % 2);
                end
                if (n > 0) begin
                    vec++; if (t - last_t != 3) begin
                        errs++; $display("FAIL alt_spacing: got %0d want 3", t - last_t);
                    end
                end
                last_t = t; n++;
            end
        end
        a_req = 0; b_req = 0;
        vec++; if (n != 6) begin
            errs++; $display("FAIL alt_count: got %0d want 6", n);
        end
        shadow[8'h10] = da; shadow[8'h20] = db; last_b = 1;
        @(negedge clk);
    endtask

    task automatic test_enable();
        logic [7:0] r;
        r = 8'($urandom);
        ena = 0; a_wr = 0; a_addr = r; a_req = 1;
        repeat (10) begin
            @(negedge clk);
            vec++; if ({bank_we, bank_re, busy} !== 3'b000) begin
                errs++; $display("FAIL ena_block: got we/re/busy=%b want 000", {bank_we, bank_re, busy});
            end
        end
        ena = 1;
        @(negedge clk);
        vec++; if ({busy, bank_re, grant_id} !== 3'b110) begin
            errs++; $display("FAIL ena_grant: got busy/re/grant=%b want 110", {busy, bank_re, grant_id});
        end
        @(negedge clk);
        ena = 0;
        @(negedge clk);
        vec++; if ({a_ack, a_rdata} !== {1'b1, shadow[r]}) begin
            errs++; $display("FAIL ena_inflight: got ack=%b rdata=%h want 1 %h", a_ack, a_rdata, shadow[r]);
        end
        a_req = 0; ena = 1; exp_rd_a = shadow[r]; last_b = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [7:0] ra, rb;
        int ta = 0, tb = 0;
        ra = 8'($urandom); rb = 8'($urandom);
        b_wr = 0; b_addr = rb; b_req = 1;
        @(negedge clk);
        vec++; if (bank_re !== 1'b1) begin
            errs++; $display("FAIL rst_mid_strobe: got %b want 1", bank_re);
        end
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        vec++; if ({bank_re, b_ack, busy} !== 3'b000) begin
            errs++; $display("FAIL rst_mid_drop: got re/ack/busy=%b want 000", {bank_re, b_ack, busy});
        end
        b_req = 0;
        @(negedge clk);
        rst_n = 1; exp_rd_a = 0; exp_rd_b = 0; last_b = 1;
        @(negedge clk);
        vec++; if ({b_ack, b_rdata, a_rdata} !== 17'h0) begin
            errs++; $display("FAIL rst_mid_clear: got ack=%b b_rdata=%h a_rdata=%h want 0 00 00", b_ack, b_rdata, a_rdata);
        end
        a_wr = 0; a_addr = ra; b_addr = rb; a_req = 1; b_req = 1;
        for (int t = 1; t <= 15 && (ta == 0 || tb == 0); t++) begin
            @(negedge clk);
            if (a_ack) begin
                ta = t; a_req = 0;
                vec++; if (a_rdata !== shadow[ra]) begin
                    errs++; $display("FAIL rst_mid_a_rdata: got %h want %h", a_rdata, shadow[ra]);
                end
            end
            if (b_ack) begin
                tb = t; b_req = 0;
                vec++; if (b_rdata !== shadow[rb]) begin
                    errs++; $display("FAIL rst_mid_b_rdata: got %h want %h", b_rdata, shadow[rb]);
                end
            end
        end
        a_req = 0; b_req = 0;
        vec++; if (ta != 3 || tb != 7) begin
            errs++; $display("FAIL rst_mid_order: got a@%0d b@%0d want a@3 b@7", ta, tb);
        end
        exp_rd_a = shadow[ra]; exp_rd_b = shadow[rb]; last_b = 1;
        @(negedge clk);
    endtask

    task automatic test_sweep();
        for (int r = 0; r < 2; r++) begin
            logic [7:0] ad;
            int         t_ack [4], n_ack [4];
            logic [7:0] rd [4];
            ad = r ? 8'h34 : 8'h12;
            for (int k = 0; k < 4; k++) begin t_ack[k] = 0; n_ack[k] = 0; rd[k] = 0; end
            sw_addr = ad; sw_req = 1;
            for (int t = 1; t <= 10; t++) begin
                @(negedge clk);
                if (t == 1) sw_req = 0;
                for (int k = 0; k < 4; k++) if (sw_ack[k]) begin
                    n_ack[k]++; t_ack[k] = t; rd[k] = sw_rdata[k];
                end
            end
            for (int k = 0; k < 4; k++) begin
                vec++; if (n_ack[k] != 1 || t_ack[k] != 3 + k) begin
                    errs++; $display("FAIL sweep_lat%0d: got %0d acks last@%0d want 1 ack @%0d", k + 1, n_ack[k], t_ack[k], 3 + k);
                end
                vec++; if (rd[k] !== (ad ^ 8'h5A)) begin
                    errs++; $display("FAIL sweep_rdata%0d: got %h want %h", k + 1, rd[k], ad ^ 8'h5A);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            bit         ra, rb, wa, wb, first_b, p, wr;
            logic [7:0] ad_a, ad_b, wd_a, wd_b, ad;
            int         sel, ta, tb, na, nb, ea, eb, st, te;
            sel = $urandom_range(1, 3); ra = sel[0]; rb = sel[1];
            wa = 1'($urandom); wb = 1'($urandom);
            ad_a = 8'($urandom_range(0, 7)); ad_b = 8'($urandom_range(0, 7));
            wd_a = 8'($urandom); wd_b = 8'($urandom);
            first_b = (ra && rb) ? !last_b : rb;
            ta = 0; tb = 0; na = 0; nb = 0; ea = 0; eb = 0; st = 0;
            for (int s = 0; s < 2; s++) begin
                p = s ? !first_b : first_b;
                if (!(p ? rb : ra)) continue;
                wr = p ? wb : wa;
                ad = p ? ad_b : ad_a;
                te = st + (wr ? 2 : 2 + L);
                if (p) eb = te; else ea = te;
                if (wr) shadow[ad] = p ? wd_b : wd_a;
                else if (p) exp_rd_b = shadow[ad];
                else exp_rd_a = shadow[ad];
                st = te + 1; last_b = p;
            end
            a_wr = wa; a_addr = ad_a; a_wdata = wd_a; a_req = ra;
            b_wr = wb; b_addr = ad_b; b_wdata = wd_b; b_req = rb;
            for (int t = 1; t <= 14; t++) begin
                @(negedge clk);
                vec++; if ((a_ack && b_ack) || (bank_we && bank_re)) begin
                    errs++; $display("FAIL rnd_excl: got acks=%b%b strobes=%b%b want not both", a_ack, b_ack, bank_we, bank_re);
                end
                if (a_ack) begin
                    na++; ta = t; a_req = 0;
                    vec++; if (a_rdata !== exp_rd_a) begin
                        errs++; $display("FAIL rnd_a_rdata: it %0d got %h want %h", it, a_rdata, exp_rd_a);
                    end
                end
                if (b_ack) begin
                    nb++; tb = t; b_req = 0;
                    vec++; if (b_rdata !== exp_rd_b) begin
                        errs++; $display("FAIL rnd_b_rdata: it %0d got %h want %h", it, b_rdata, exp_rd_b);
                    end
                end
            end
            a_req = 0; b_req = 0;
            vec++; if (na != int'(ra) || ta != ea || nb != int'(rb) || tb != eb) begin
                errs++; $display("FAIL rnd_timing: it %0d got a %0dx@%0d b %0dx@%0d want a %0dx@%0d b %0dx@%0d",
                                 it, na, ta, nb, tb, ra, ea, rb, eb);
            end
            vec++; if (busy !== 1'b0) begin
                errs++; $display("FAIL rnd_idle: it %0d busy got %b want 0", it, busy);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            mem[i] <= v;
            shadow[i] = v;
        end
        test_reset();
        test_write_a();
        test_read_b();
        test_alternate();
        test_enable();
        test_reset_mid();
        test_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
Shares the single register-bank application port between two bus peripherals: port A (SPI side) and port B (I2C side).
- Arbitrates with round-robin priority.
- Sequences each access: address/data hold, one-cycle write or read strobe, read-latency wait, one-cycle ack to the winner.
- Sits between both peripheral front-ends and the register bank; the bank sees exactly one access at a time.

Parameters:
ADDR_W, 8, address width of requester and bank ports
DATA_W, 8, data width of requester and bank ports
RD_LATENCY, 1, cycles from bank_re strobe to valid bank_rdata; legal range 1..4

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; low blocks new grants
a_req  input  1  port A request, level, held until a_ack
a_wr  input  1  port A direction: 1 write, 0 read
a_addr  input  ADDR_W  port A address
a_wdata  input  DATA_W  port A write data
a_ack  output  1  port A completion, one-cycle pulse
a_rdata  output  DATA_W  port A read data, registered
b_req  input  1  port B request
b_wr  input  1  port B direction
b_addr  input  ADDR_W  port B address
b_wdata  input  DATA_W  port B write data
b_ack  output  1  port B completion pulse
b_rdata  output  DATA_W  port B read data, registered
bank_addr  output  ADDR_W  bank address, registered
bank_wdata  output  DATA_W  bank write data, registered
bank_we  output  1  bank write strobe, one cycle
bank_re  output  1  bank read strobe, one cycle
bank_rdata  input  DATA_W  bank read data
busy  output  1  transaction in flight (state != IDLE)
grant_id  output  1  owner of current/last transaction: 0 = A, 1 = B

Behaviour:
Reset values:
- All outputs 0; rdata registers 0.
- FSM = IDLE; round-robin pointer favours A.
- Reset is asynchronous. Asserting it mid-transaction drops strobes and ack immediately, with no completion.

FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If ena=1 and any req=1, pick the winner and go ISSUE.
  - Latch the winner's addr, wdata and wr into bank_addr, bank_wdata and an internal dir flag.
  - Set grant_id to the winner.
- ISSUE (exactly one cycle): bank_we = dir; bank_re = ~dir. Write → DONE. Read → WAIT.
- WAIT:
  - Lasts exactly RD_LATENCY cycles.
  - On the last WAIT cycle, bank_rdata is registered into the winner's rdata register. The other port's rdata is unchanged.
  - Then → DONE.
- DONE: winner's ack = 1 for one cycle → IDLE.

Latency (req first high in IDLE at cycle 0):
- Write: strobe in cycle 1, ack in cycle 2.
- Read: strobe in cycle 1, ack in cycle 2+RD_LATENCY, with rdata valid from that same cycle.

Arbitration:
- Single requester wins.
- If both request, the port not granted last wins; the pointer updates on every grant.
- A waiting requester is delayed by at most one transaction of the other port.

Handshake:
- req, addr, wdata and wr must be stable from req rise until ack. They are sampled only at grant; later changes are ignored.
- A req dropped after grant does not cancel the access; the access completes and ack still pulses.
- A req still high in the cycle after ack is treated as a new request. The earliest re-grant is the IDLE cycle following DONE.

Other rules:
- a_rdata and b_rdata hold their values until that port's next read completes. Writes never alter them.
- ena low: no grant in IDLE; an in-flight transaction completes normally. A pending req waits.
- Never both acks or both strobes high in the same cycle; bank_we and bank_re are mutually exclusive.
- busy = 1 in ISSUE, WAIT and DONE.

Test Plan:
1. Write from A: addr 0x05, wdata 0xA5, req at cycle 0 → bank_we=1 with bank_addr=0x05, bank_wdata=0xA5 in cycle 1; a_ack in cycle 2; b_ack never high.
2. Read from B, RD_LATENCY=1, addr 0x03: bank model returns 0x3C one cycle after bank_re → bank_re in cycle 1, b_ack in cycle 3 with b_rdata=0x3C; a_rdata unchanged.
3. After reset, a_req and b_req rise in the same cycle → A served first, B next. With both held continuously for 6 transactions, grant_id alternates A,B,A,B,A,B.
4. ena=0 with a_req=1 for 10 cycles → no strobes, busy=0. ena rises → grant the next cycle. ena dropped during WAIT → transaction still acks.
5. Reset asserted during WAIT of a B read → bank_re, b_ack and busy go 0 immediately. After release, b_rdata=0, pointer favours A, and a fresh B read completes normally.
6. Sweep RD_LATENCY=1..4 → read ack at cycle 2+RD_LATENCY in each case. A req dropped in cycle 1 still gets its ack.
